pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Shares the single cacheline-wide physical memory port between three requesters: instruction cache (`i_`), load/store-queue data cache (`lsq_`), and the next-line prefetcher (`pref_`). Instruction and data requests alternate when both are pending; the prefetcher is served only when no demand request is pending. The block latches the winner's request and routes the memory response back to the winner. It exports `arbiter_idle`, which gates prefetch issue.

## Interface
- `ADDR_W`, default 32: address width.
- `LINE_W`, default 256: cacheline width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_pmem_read_cla` in 1, `i_pmem_write_cla` in 1: I-cache request.
- `i_pmem_address_cla` in ADDR_W, `i_pmem_wdata_256_cla` in LINE_W: I-cache address and write data.
- `i_pmem_resp_cla` out 1, `i_pmem_rdata_256_cla` out LINE_W: I-cache response.
- `lsq_pmem_read_cla`, `lsq_pmem_write_cla`, `lsq_pmem_address_cla`, `lsq_pmem_wdata_256_cla` in: data-side request, same widths.
- `lsq_pmem_resp_cla` out 1, `lsq_pmem_rdata_256_cla` out LINE_W: data-side response.
- `pref_pmem_read_cla`, `pref_pmem_write_cla`, `pref_pmem_address_cla`, `pref_pmem_wdata_256_cla` in: prefetcher request. Write is unused but honoured.
- `pref_pmem_resp_cla` out 1, `pref_pmem_rdata_256_cla` out LINE_W: prefetcher response.
- `pmem_read` out 1, `pmem_write` out 1, `pmem_address` out ADDR_W, `pmem_wdata_256` out LINE_W: memory request.
- `pmem_resp` in 1, `pmem_rdata_256` in LINE_W: memory response.
- `arbiter_idle` out 1: high exactly when the FSM is in IDLE.

## Operation
- FSM states:
  - IDLE → GRANT: taken when any requester has read or write high.
  - GRANT → WAIT: unconditional, one cycle.
  - WAIT → DONE: on `pmem_resp`.
  - DONE → IDLE: unconditional, one cycle.
- Selection in IDLE:
  - Only I or only LSQ pending: serve that one.
  - I and LSQ both pending: serve the one not served last. The `last_demand` flag is set to 0 for I and 1 for LSQ, updated on each demand grant. Its reset value is 0, so LSQ wins the first tie.
  - Prefetcher: served only when neither I nor LSQ is pending.
  - Prefetch grants do not change `last_demand`.
- On the IDLE→GRANT edge, latch into the request register: owner ID, read/write, address, wdata.
  - If one requester asserts both read and write, latch a write.
- GRANT and WAIT: drive `pmem_read`/`pmem_write`, `pmem_address`, and `pmem_wdata_256` from the latched register only. Requester inputs changing mid-transaction have no effect.
- WAIT:
  - `<owner>_pmem_resp_cla` = `pmem_resp`, combinationally.
  - `<owner>_pmem_rdata_256_cla` = `pmem_rdata_256`.
  - Non-owner resp outputs stay 0.
  - All rdata outputs are driven from `pmem_rdata_256` at all times; only resp is qualified.
- DONE: no memory request is driven. This gives the owner one cycle to drop its request, so it is not re-granted on a stale request.
- A requester that withdraws its request during GRANT/WAIT still completes. Its response is delivered and may be ignored.

## Timing
- Reset, asynchronous on `rst`=0:
  - state = IDLE, `last_demand` = 0, latched register = 0.
  - `pmem_read` = `pmem_write` = 0, `pmem_address` = 0, `pmem_wdata_256` = 0.
  - All resp outputs = 0; `arbiter_idle` = 1.
- Reset mid-transaction abandons the in-flight access. The memory model is reset on the same signal.
- Latency:
  - Request sampled at edge N (IDLE).
  - `pmem_read` high from cycle N+1 (GRANT) until the edge after `pmem_resp`.
  - Response forwarded in the same cycle as `pmem_resp`.
  - IDLE is re-entered 2 cycles after `pmem_resp` (DONE, then IDLE).
  - Back-to-back demand transactions therefore cost memory latency plus 3 cycles overhead.
- `pmem_resp` while not in WAIT: ignored. Responses are not routed outside WAIT.
- `arbiter_idle` is registered-state decoded and glitch-free. It is low from the first cycle of GRANT through DONE.

## Structure
- Package `pmem_arb_pkg`:
  - `arb_state_t` enum {IDLE, GRANT, WAIT, DONE}.
  - `req_id_t` enum {REQ_I, REQ_LSQ, REQ_PREF}.
  - `req_t` struct {id, rd, wr, addr, wdata}.
- One sub-module, `pmem_req_reg`: a load-enabled `req_t` register with asynchronous active-low clear.
- Arbiter FSM, selection logic and response demux live in `pmem_arbiter`.

## Test plan
- **Single I-read:** I read at 0x1000, memory latency 5.
  - `pmem_read`/`pmem_address`=0x1000 from the cycle after the request.
  - `i_pmem_resp_cla` pulses once with the data.
  - `lsq`/`pref` resp stay 0.
  - `arbiter_idle` back to 1 two cycles after resp.
- **I/LSQ tie alternation:** I and LSQ request continuously from reset, each re-requesting after its resp.
  - Grant order: LSQ, I, LSQ, I.
  - Addresses match each owner.
- **Prefetch starvation rule:** pref requests 0x2020 while LSQ write 0x3000 is pending.
  - LSQ write is served first, with `pmem_write`=1 and wdata matching.
  - Pref read of 0x2020 is served only afterwards.
- **Input change during WAIT:** LSQ changes its address from 0x4000 to 0x5000 mid-transaction.
  - `pmem_address` stays 0x4000 until resp.
- **Reset mid-WAIT:** assert `rst`=0 while in WAIT.
  - `pmem_read`, all resp = 0 immediately (asynchronous); `arbiter_idle`=1.
  - After release, the next request is granted LSQ-first.
- **Read+write from one requester:** I asserts both read and write.
  - Arbiter issues `pmem_write`=1 only.

Source files
------------

// File: rtl/pmem_arb_pkg.sv
// Shared types for the physical-memory port arbiter.
// Request register layout, FSM states and requester IDs.
package pmem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_I,
    REQ_LSQ,
    REQ_PREF
  } req_id_t;

  typedef struct packed {
    req_id_t                 id;
    logic                    rd;
    logic                    wr;
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_LINE_W-1:0]   wdata;
  } req_t;

endpackage

// File: rtl/pmem_req_reg.sv
// Load-enabled holding register for the granted request.
// Cleared asynchronously so a reset abandons the in-flight access.
module pmem_req_reg
  import pmem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  req_t i_d,
  output req_t o_q
);

  req_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Three-way arbiter for the cacheline-wide physical memory port.
// Demand sides alternate on ties; the prefetcher only fills idle slots.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read_cla,
  input  logic              i_pmem_write_cla,
  input  logic [ADDR_W-1:0] i_pmem_address_cla,
  input  logic [LINE_W-1:0] i_pmem_wdata_256_cla,
  output logic              i_pmem_resp_cla,
  output logic [LINE_W-1:0] i_pmem_rdata_256_cla,
  input  logic              lsq_pmem_read_cla,
  input  logic              lsq_pmem_write_cla,
  input  logic [ADDR_W-1:0] lsq_pmem_address_cla,
  input  logic [LINE_W-1:0] lsq_pmem_wdata_256_cla,
  output logic              lsq_pmem_resp_cla,
  output logic [LINE_W-1:0] lsq_pmem_rdata_256_cla,
  input  logic              pref_pmem_read_cla,
  input  logic              pref_pmem_write_cla,
  input  logic [ADDR_W-1:0] pref_pmem_address_cla,
  input  logic [LINE_W-1:0] pref_pmem_wdata_256_cla,
  output logic              pref_pmem_resp_cla,
  output logic [LINE_W-1:0] pref_pmem_rdata_256_cla,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata_256,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata_256,
  output logic              arbiter_idle
);

  arb_state_t r_state;
  logic       r_last_demand;
  logic       r_busy;
  logic       r_idle;
  req_t       r_req;

  logic    w_i_pend;
  logic    w_lsq_pend;
  logic    w_pref_pend;
  logic    w_any;
  logic    w_load;
  logic    w_wait;
  req_id_t w_sel_id;
  req_t    w_sel;

  assign w_i_pend    = i_pmem_read_cla | i_pmem_write_cla;
  assign w_lsq_pend  = lsq_pmem_read_cla | lsq_pmem_write_cla;
  assign w_pref_pend = pref_pmem_read_cla | pref_pmem_write_cla;
  assign w_any       = w_i_pend | w_lsq_pend | w_pref_pend;
  assign w_load      = (r_state == IDLE) & w_any;

  always_comb begin
    w_sel_id = REQ_PREF;
    unique case (1'b1)
      w_i_pend && w_lsq_pend:
        w_sel_id = r_last_demand ? REQ_I : REQ_LSQ;
      w_i_pend && !w_lsq_pend:
        w_sel_id = REQ_I;
      !w_i_pend && w_lsq_pend:
        w_sel_id = REQ_LSQ;
      default:
        w_sel_id = REQ_PREF;
    endcase
  end

  // Write wins when a requester raises both strobes.
  always_comb begin
    w_sel    = '0;
    w_sel.id = w_sel_id;
    unique case (w_sel_id)
      REQ_I: begin
        w_sel.wr    = i_pmem_write_cla;
        w_sel.rd    = i_pmem_read_cla & ~i_pmem_write_cla;
        w_sel.addr  = ARB_ADDR_W'(i_pmem_address_cla);
        w_sel.wdata = ARB_LINE_W'(i_pmem_wdata_256_cla);
      end
      REQ_LSQ: begin
        w_sel.wr    = lsq_pmem_write_cla;
        w_sel.rd    = lsq_pmem_read_cla & ~lsq_pmem_write_cla;
        w_sel.addr  = ARB_ADDR_W'(lsq_pmem_address_cla);
        w_sel.wdata = ARB_LINE_W'(lsq_pmem_wdata_256_cla);
      end
      default: begin
        w_sel.wr    = pref_pmem_write_cla;
        w_sel.rd    = pref_pmem_read_cla & ~pref_pmem_write_cla;
        w_sel.addr  = ARB_ADDR_W'(pref_pmem_address_cla);
        w_sel.wdata = ARB_LINE_W'(pref_pmem_wdata_256_cla);
      end
    endcase
  end

  pmem_req_reg u_req_reg (
    .clk    (clk),
    .rst_n  (rst),
    .i_load (w_load),
    .i_d    (w_sel),
    .o_q    (r_req)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_last_demand <= 1'b0;
      r_busy        <= 1'b0;
      r_idle        <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_busy  <= 1'b1;
            r_idle  <= 1'b0;
            if (w_sel_id == REQ_I) begin
              r_last_demand <= 1'b0;
            end else if (w_sel_id == REQ_LSQ) begin
              r_last_demand <= 1'b1;
            end
          end
        end
        GRANT: r_state <= WAIT;
        WAIT: begin
          if (pmem_resp) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign pmem_read      = r_busy & r_req.rd;
  assign pmem_write     = r_busy & r_req.wr;
  assign pmem_address   = ADDR_W'(r_req.addr);
  assign pmem_wdata_256 = LINE_W'(r_req.wdata);
  assign arbiter_idle   = r_idle;

  assign w_wait = (r_state == WAIT) & pmem_resp;

  assign i_pmem_resp_cla    = w_wait & (r_req.id == REQ_I);
  assign lsq_pmem_resp_cla  = w_wait & (r_req.id == REQ_LSQ);
  assign pref_pmem_resp_cla = w_wait & (r_req.id == REQ_PREF);

  assign i_pmem_rdata_256_cla    = pmem_rdata_256;
  assign lsq_pmem_rdata_256_cla  = pmem_rdata_256;
  assign pref_pmem_rdata_256_cla = pmem_rdata_256;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter with a fixed-latency memory model.
// Expected grants are queued in predicted order and popped on each resp.
module tb_pmem_arbiter;

  localparam int LAT = 5;

  typedef struct {
    logic [1:0]   id;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } txn_t;

  logic         clk;
  logic         rst;
  logic         i_rd, i_wr, i_resp;
  logic [31:0]  i_addr;
  logic [255:0] i_wd, i_rdat;
  logic         l_rd, l_wr, l_resp;
  logic [31:0]  l_addr;
  logic [255:0] l_wd, l_rdat;
  logic         p_rd, p_wr, p_resp;
  logic [31:0]  p_addr;
  logic [255:0] p_wd, p_rdat;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata_256, pmem_rdata_256;
  logic         arbiter_idle;

  txn_t sb[$];
  txn_t rq_i[$];
  txn_t rq_l[$];
  txn_t rq_p[$];

  int checks;
  int failures;
  int n_resp;
  int mem_cnt;

  pmem_arbiter dut (
    .clk                     (clk),
    .rst                     (rst),
    .i_pmem_read_cla         (i_rd),
    .i_pmem_write_cla        (i_wr),
    .i_pmem_address_cla      (i_addr),
    .i_pmem_wdata_256_cla    (i_wd),
    .i_pmem_resp_cla         (i_resp),
    .i_pmem_rdata_256_cla    (i_rdat),
    .lsq_pmem_read_cla       (l_rd),
    .lsq_pmem_write_cla      (l_wr),
    .lsq_pmem_address_cla    (l_addr),
    .lsq_pmem_wdata_256_cla  (l_wd),
    .lsq_pmem_resp_cla       (l_resp),
    .lsq_pmem_rdata_256_cla  (l_rdat),
    .pref_pmem_read_cla      (p_rd),
    .pref_pmem_write_cla     (p_wr),
    .pref_pmem_address_cla   (p_addr),
    .pref_pmem_wdata_256_cla (p_wd),
    .pref_pmem_resp_cla      (p_resp),
    .pref_pmem_rdata_256_cla (p_rdat),
    .pmem_read               (pmem_read),
    .pmem_write              (pmem_write),
    .pmem_address            (pmem_address),
    .pmem_wdata_256          (pmem_wdata_256),
    .pmem_resp               (pmem_resp),
    .pmem_rdata_256          (pmem_rdata_256),
    .arbiter_idle            (arbiter_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_data(input logic [31:0] a);
    return {8{a ^ 32'h5A3C_0F96}};
  endfunction

  function automatic txn_t mk(input logic [1:0] id, input logic rd,
                              input logic wr, input logic [31:0] a,
                              input logic [255:0] wd);
    txn_t t;
    t.id = id;
    t.rd = rd;
    t.wr = wr;
    t.addr = a;
    t.wdata = wd;
    return t;
  endfunction

  task automatic apply();
    i_rd = 0; i_wr = 0; i_addr = 0; i_wd = 0;
    l_rd = 0; l_wr = 0; l_addr = 0; l_wd = 0;
    p_rd = 0; p_wr = 0; p_addr = 0; p_wd = 0;
    if (rq_i.size() != 0) begin
      i_rd = rq_i[0].rd; i_wr = rq_i[0].wr;
      i_addr = rq_i[0].addr; i_wd = rq_i[0].wdata;
    end
    if (rq_l.size() != 0) begin
      l_rd = rq_l[0].rd; l_wr = rq_l[0].wr;
      l_addr = rq_l[0].addr; l_wd = rq_l[0].wdata;
    end
    if (rq_p.size() != 0) begin
      p_rd = rq_p[0].rd; p_wr = rq_p[0].wr;
      p_addr = rq_p[0].addr; p_wd = rq_p[0].wdata;
    end
  endtask

  task automatic tick();
    logic [2:0]   rv;
    logic [255:0] od;
    txn_t         e;
    @(negedge clk);
    if (!rst) begin
      mem_cnt = 0;
      pmem_resp = 1'b0;
      return;
    end
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_cnt = 0;
    end else if (pmem_read || pmem_write) begin
      mem_cnt++;
      if (mem_cnt == LAT) begin
        pmem_resp = 1'b1;
        pmem_rdata_256 = mem_data(pmem_address);
      end
    end
    #1;
    rv = {p_resp, l_resp, i_resp};
    if (rv != 3'b000) begin
      n_resp++;
      if (sb.size() == 0) begin
        check("sb_underflow", 256'(rv), 256'd0);
      end else begin
        e = sb.pop_front();
        od = (e.id == 2'd0) ? i_rdat : (e.id == 2'd1) ? l_rdat : p_rdat;
        check("owner", 256'(rv), 256'(3'b001 << e.id));
        check("addr", 256'(pmem_address), 256'(e.addr));
        check("rd", 256'(pmem_read), 256'(e.rd));
        check("wr", 256'(pmem_write), 256'(e.wr));
        if (e.wr) check("wdata", pmem_wdata_256, e.wdata);
        check("rdata", od, mem_data(e.addr));
      end
      if (rv[0] && rq_i.size() != 0) void'(rq_i.pop_front());
      if (rv[1] && rq_l.size() != 0) void'(rq_l.pop_front());
      if (rv[2] && rq_p.size() != 0) void'(rq_p.pop_front());
      apply();
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || rq_i.size() != 0 || rq_l.size() != 0 ||
            rq_p.size() != 0 || !arbiter_idle) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 256'(n < budget), 256'd1);
  endtask

  task automatic check_all_resp_zero(input string tag);
    check(tag, 256'({p_resp, l_resp, i_resp}), 256'd0);
  endtask

  initial begin
    int r0;
    int n;
    checks = 0; failures = 0; n_resp = 0; mem_cnt = 0;
    rst = 1'b0;
    pmem_resp = 1'b0;
    pmem_rdata_256 = '0;
    apply();
    repeat (2) @(negedge clk);
    #1;
    check("rst_idle", 256'(arbiter_idle), 256'd1);
    check("rst_read", 256'(pmem_read), 256'd0);
    check("rst_write", 256'(pmem_write), 256'd0);
    check("rst_addr", 256'(pmem_address), 256'd0);
    check("rst_wdata", pmem_wdata_256, 256'd0);
    check_all_resp_zero("rst_resp");
    @(negedge clk);
    rst = 1'b1;

    // I/LSQ tie alternation from reset
    rq_i.push_back(mk(2'd0, 1, 0, 32'hA000, '0));
    rq_i.push_back(mk(2'd0, 1, 0, 32'hA100, '0));
    rq_l.push_back(mk(2'd1, 1, 0, 32'hB000, '0));
    rq_l.push_back(mk(2'd1, 1, 0, 32'hB100, '0));
    sb.push_back(mk(2'd1, 1, 0, 32'hB000, '0));
    sb.push_back(mk(2'd0, 1, 0, 32'hA000, '0));
    sb.push_back(mk(2'd1, 1, 0, 32'hB100, '0));
    sb.push_back(mk(2'd0, 1, 0, 32'hA100, '0));
    apply();
    wait_drain(200);

    // single I read with latency checks
    rq_i.push_back(mk(2'd0, 1, 0, 32'h1000, '0));
    sb.push_back(mk(2'd0, 1, 0, 32'h1000, '0));
    apply();
    tick();
    check("grant_read", 256'(pmem_read), 256'd1);
    check("grant_addr", 256'(pmem_address), 256'h1000);
    check("grant_idle", 256'(arbiter_idle), 256'd0);
    r0 = n_resp;
    n = 0;
    while (n_resp == r0 && n < 50) begin
      tick();
      n++;
    end
    check("resp_timeout", 256'(n < 50), 256'd1);
    tick();
    check("done_idle", 256'(arbiter_idle), 256'd0);
    check("done_read", 256'(pmem_read), 256'd0);
    tick();
    check("back_idle", 256'(arbiter_idle), 256'd1);
    wait_drain(50);

    // stray pmem_resp in IDLE is not routed
    pmem_resp = 1'b1;
    pmem_rdata_256 = mem_data(32'hDEAD);
    #1;
    check_all_resp_zero("stray_resp");
    tick();
    check("stray_idle", 256'(arbiter_idle), 256'd1);

    // prefetch waits behind a demand write
    rq_p.push_back(mk(2'd2, 1, 0, 32'h2020, '0));
    rq_l.push_back(mk(2'd1, 0, 1, 32'h3000, {8{32'hC0DE_0001}}));
    sb.push_back(mk(2'd1, 0, 1, 32'h3000, {8{32'hC0DE_0001}}));
    sb.push_back(mk(2'd2, 1, 0, 32'h2020, '0));
    apply();
    wait_drain(100);

    // address change during WAIT is ignored
    rq_l.push_back(mk(2'd1, 1, 0, 32'h4000, '0));
    sb.push_back(mk(2'd1, 1, 0, 32'h4000, '0));
    apply();
    repeat (3) tick();
    l_addr = 32'h5000;
    tick();
    check("addr_hold", 256'(pmem_address), 256'h4000);
    wait_drain(50);

    // reset in WAIT abandons the access
    rq_l.push_back(mk(2'd1, 1, 0, 32'h6000, '0));
    apply();
    repeat (3) tick();
    check("pre_rst_read", 256'(pmem_read), 256'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_read", 256'(pmem_read), 256'd0);
    check("mid_rst_idle", 256'(arbiter_idle), 256'd1);
    check_all_resp_zero("mid_rst_resp");
    rq_l.delete();
    apply();
    tick();
    rst = 1'b1;
    rq_i.push_back(mk(2'd0, 1, 0, 32'h7000, '0));
    rq_l.push_back(mk(2'd1, 1, 0, 32'h8000, '0));
    sb.push_back(mk(2'd1, 1, 0, 32'h8000, '0));
    sb.push_back(mk(2'd0, 1, 0, 32'h7000, '0));
    apply();
    wait_drain(100);

    // read+write from one requester becomes a write
    rq_i.push_back(mk(2'd0, 1, 1, 32'h9000, {8{32'h1234_5678}}));
    sb.push_back(mk(2'd0, 0, 1, 32'h9000, {8{32'h1234_5678}}));
    apply();
    tick();
    check("rw_read", 256'(pmem_read), 256'd0);
    check("rw_write", 256'(pmem_write), 256'd1);
    wait_drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
